// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, funct3 encodings for loads/stores,
// the EX/MEM and MEM/WB pipeline records, and the memory-stage FSM states.
package rv32i_types;

  localparam int unsigned PHYS_W = 6;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_f3_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       inst;
    rv32i_opcode       opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic [31:0]       rs1_v;
    logic [31:0]       rs2_v;
    logic [31:0]       alu_out;
    logic              br_en;
    logic [31:0]       u_imm;
    logic [3:0]        regfilemux_sel;
    logic              regf_we;
    logic [PHYS_W-1:0] rs1_phys;
    logic [PHYS_W-1:0] rs2_phys;
    logic [PHYS_W-1:0] dest_phys_new;
    logic [PHYS_W-1:0] dest_phys_old;
    logic [4:0]        dest_arch;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic [31:0]       rs1_v;
    logic [31:0]       rs2_v;
    logic [31:0]       alu_out;
    logic              br_en;
    logic [31:0]       u_imm;
    logic [3:0]        regfilemux_sel;
    logic              regf_we;
    logic [31:0]       mem_rdata;
    logic [PHYS_W-1:0] rs1_phys;
    logic [PHYS_W-1:0] rs2_phys;
    logic [PHYS_W-1:0] dest_phys_new;
    logic [PHYS_W-1:0] dest_phys_old;
    logic [4:0]        dest_arch;
  } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the memory stage.
// Ports:
//   funct3, opcode  - access type of the current instruction
//   addr_lo         - low two address bits (byte offset in the word)
//   rs2_v           - store source value
//   rdata           - raw word returned by data memory
//   rmask / wmask   - byte-lane masks (zero unless opcode is load / store)
//   wdata           - store data shifted into its byte lanes
//   load_data       - shifted and sign/zero-extended load result
//   misaligned      - load/store whose size does not fit its offset
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  rv32i_opcode opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_v,
  input  logic [31:0] rdata,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic        is_load;
  logic        is_store;
  logic [3:0]  size_mask;
  logic [3:0]  lane_mask;
  logic [31:0] shifted;

  assign is_load  = (opcode == op_load);
  assign is_store = (opcode == op_store);

  // Load and store funct3 share the size encoding in bits [1:0].
  always_comb begin
    size_mask = 4'b0000;
    unique case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign lane_mask = size_mask << addr_lo;
  assign rmask     = is_load  ? lane_mask : 4'b0000;
  assign wmask     = is_store ? lane_mask : 4'b0000;
  assign wdata     = rs2_v << {addr_lo, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      unique case (funct3[1:0])
        2'b01:   misaligned = addr_lo[0];
        2'b10:   misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    case (load_f3_t'(funct3))
      lb:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      lh:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      lbu:     load_data = {24'h0, shifted[7:0]};
      lhu:     load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline.
// Issues data-memory requests for loads/stores, waits for the response while
// holding mem_stall high, extends load data and owns the MEM/WB register.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ex_mem              - EX/MEM record (held stable while mem_stall=1)
//   mem_wb              - registered MEM/WB record
//   mem_stall           - freezes IF/ID/EX and the EX/MEM register
//   dmem_addr           - word-aligned request address
//   dmem_rmask/wmask    - byte masks, nonzero only in the request cycle
//   dmem_wdata          - lane-shifted store data
//   dmem_rdata/resp     - read data and one-cycle completion pulse
//   misalign_err        - one-cycle pulse after a misaligned access
//   perf_stall_cnt      - saturating count of stalled cycles
module mem_stage
  import rv32i_types::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_stage_reg_t ex_mem,
  output mem_wb_stage_reg_t mem_wb,
  output logic              mem_stall,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_resp,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  mem_state_t        state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  mem_wb_stage_reg_t mem_wb_q, mem_wb_d;
  logic              misalign_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        issue;
  logic        misaligned;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign is_load  = (ex_mem.opcode == op_load);
  assign is_store = (ex_mem.opcode == op_store);
  assign mem_op   = ex_mem.valid & (is_load | is_store);

  mem_align u_align (
    .funct3     (ex_mem.funct3),
    .opcode     (ex_mem.opcode),
    .addr_lo    (ex_mem.alu_out[1:0]),
    .rs2_v      (ex_mem.rs2_v),
    .rdata      (dmem_rdata),
    .rmask      (rmask),
    .wmask      (wmask),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // Next state and stall; a response in IDLE is ignored by construction.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          issue     = 1'b1;
          mem_stall = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_addr  = (state_q == WAIT) ? addr_q : {ex_mem.alu_out[31:2], 2'b00};
  assign dmem_rmask = issue ? rmask : 4'b0000;
  assign dmem_wmask = issue ? wmask : 4'b0000;
  assign dmem_wdata = wdata;

  // Next MEM/WB record; an invalid EX/MEM record becomes an all-zero bubble.
  always_comb begin
    mem_wb_d = '0;
    if (ex_mem.valid) begin
      mem_wb_d.valid          = 1'b1;
      mem_wb_d.pc             = ex_mem.pc;
      mem_wb_d.inst           = ex_mem.inst;
      mem_wb_d.rd_s           = ex_mem.rd_s;
      mem_wb_d.rs1_s          = ex_mem.rs1_s;
      mem_wb_d.rs2_s          = ex_mem.rs2_s;
      mem_wb_d.rs1_v          = ex_mem.rs1_v;
      mem_wb_d.rs2_v          = ex_mem.rs2_v;
      mem_wb_d.alu_out        = ex_mem.alu_out;
      mem_wb_d.br_en          = ex_mem.br_en;
      mem_wb_d.u_imm          = ex_mem.u_imm;
      mem_wb_d.regfilemux_sel = ex_mem.regfilemux_sel;
      // A misaligned access retires without writing the register file.
      mem_wb_d.regf_we        = ex_mem.regf_we & ~(mem_op & misaligned);
      mem_wb_d.mem_rdata      = (is_load && state_q == WAIT) ? load_data : 32'h0;
      mem_wb_d.rs1_phys       = ex_mem.rs1_phys;
      mem_wb_d.rs2_phys       = ex_mem.rs2_phys;
      mem_wb_d.dest_phys_new  = ex_mem.dest_phys_new;
      mem_wb_d.dest_phys_old  = ex_mem.dest_phys_old;
      mem_wb_d.dest_arch      = ex_mem.dest_arch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mem_wb_q    <= '0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= (state_q == IDLE) & mem_op & misaligned;
      if (issue) begin
        addr_q <= {ex_mem.alu_out[31:2], 2'b00};
      end
      if (!mem_stall) begin
        mem_wb_q <= mem_wb_d;
      end
      if (mem_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign mem_wb         = mem_wb_q;
  assign misalign_err   = misalign_q;
  assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  ex_mem_stage_reg_t ex_mem;
  mem_wb_stage_reg_t mem_wb;
  logic              mem_stall;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              misalign_err;
  logic [31:0]       perf_stall_cnt;

  int checks = 0;
  int errors = 0;
  mem_wb_stage_reg_t exp_q[$];

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_mem         (ex_mem),
    .mem_wb         (mem_wb),
    .mem_stall      (mem_stall),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .misalign_err   (misalign_err),
    .perf_stall_cnt (perf_stall_cnt)
  );

  function automatic ex_mem_stage_reg_t mk_op(rv32i_opcode op, logic [2:0] f3, logic [31:0] a,
                                              logic [31:0] rs2, logic we);
    ex_mem_stage_reg_t e;
    e = '0;
    e.valid          = 1'b1;
    e.pc             = 32'h0000_0100 + a;
    e.inst           = {a[24:0], op};
    e.opcode         = op;
    e.funct3         = f3;
    e.rd_s           = 5'd7;
    e.rs1_s          = 5'd3;
    e.rs2_s          = 5'd4;
    e.rs1_v          = 32'h1111_0000;
    e.rs2_v          = rs2;
    e.alu_out        = a;
    e.br_en          = a[2];
    e.u_imm          = 32'hABC0_0000;
    e.regfilemux_sel = 4'd5;
    e.regf_we        = we;
    e.rs1_phys       = 6'd33;
    e.rs2_phys       = 6'd34;
    e.dest_phys_new  = 6'd40;
    e.dest_phys_old  = 6'd12;
    e.dest_arch      = 5'd7;
    return e;
  endfunction

  function automatic mem_wb_stage_reg_t exp_wb(ex_mem_stage_reg_t e, logic we, logic [31:0] rd);
    mem_wb_stage_reg_t w;
    w = '0;
    w.valid          = 1'b1;
    w.pc             = e.pc;
    w.inst           = e.inst;
    w.rd_s           = e.rd_s;
    w.rs1_s          = e.rs1_s;
    w.rs2_s          = e.rs2_s;
    w.rs1_v          = e.rs1_v;
    w.rs2_v          = e.rs2_v;
    w.alu_out        = e.alu_out;
    w.br_en          = e.br_en;
    w.u_imm          = e.u_imm;
    w.regfilemux_sel = e.regfilemux_sel;
    w.regf_we        = we;
    w.mem_rdata      = rd;
    w.rs1_phys       = e.rs1_phys;
    w.rs2_phys       = e.rs2_phys;
    w.dest_phys_new  = e.dest_phys_new;
    w.dest_phys_old  = e.dest_phys_old;
    w.dest_arch      = e.dest_arch;
    return w;
  endfunction

  task automatic test_reset();
    mem_wb_stage_reg_t zero_wb;
    zero_wb = '0;
    rst_n = 1'b0;
    ex_mem = '0;
    dmem_resp = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_wb !== zero_wb) begin
      errors++;
      $display("FAIL reset_mem_wb got %h want %h", mem_wb, zero_wb);
    end
    checks++;
    if ({misalign_err, dmem_rmask, dmem_wmask, mem_stall} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got err=%b rmask=%b wmask=%b stall=%b want all 0",
               misalign_err, dmem_rmask, dmem_wmask, mem_stall);
    end
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got %0d want 0", perf_stall_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    ex_mem_stage_reg_t e;
    mem_wb_stage_reg_t got_exp;
    e = mk_op(op_reg, 3'b000, 32'h0000_0010, 32'h5, 1'b1);
    @(negedge clk);
    ex_mem = e;
    dmem_resp = 1'b0;
    #1;
    checks++;
    if ({mem_stall, dmem_rmask, dmem_wmask} !== 9'b0) begin
      errors++;
      $display("FAIL alu_no_request got stall=%b rmask=%b wmask=%b want 0",
               mem_stall, dmem_rmask, dmem_wmask);
    end
    exp_q.push_back(exp_wb(e, 1'b1, 32'h0));
    @(posedge clk);
    #1;
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if (mem_wb !== got_exp) begin
      errors++;
      $display("FAIL alu_mem_wb got %h want %h", mem_wb, got_exp);
    end
    checks++;
    if (mem_wb.alu_out !== 32'h10 || mem_wb.valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_fields got alu_out=%h valid=%b want 00000010 1",
               mem_wb.alu_out, mem_wb.valid);
    end
  endtask

  // Load with a configurable number of wait cycles before the response.
  task automatic test_load(string name, logic [2:0] f3, logic [31:0] a, logic [31:0] rdata,
                           int waits, logic [3:0] exp_mask, logic [31:0] exp_data);
    ex_mem_stage_reg_t e;
    mem_wb_stage_reg_t got_exp;
    logic [31:0] cnt0;
    e = mk_op(op_load, f3, a, 32'h0, 1'b1);
    @(negedge clk);
    ex_mem = e;
    dmem_resp = 1'b0;
    #1;
    cnt0 = perf_stall_cnt;
    checks++;
    if (dmem_rmask !== exp_mask || dmem_wmask !== 4'b0 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL %s_request got rmask=%b wmask=%b stall=%b want %b 0000 1",
               name, dmem_rmask, dmem_wmask, mem_stall, exp_mask);
    end
    checks++;
    if (dmem_addr !== {a[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s_addr got %h want %h", name, dmem_addr, {a[31:2], 2'b00});
    end
    @(posedge clk);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (dmem_rmask !== 4'b0 || mem_stall !== 1'b1 || dmem_addr !== {a[31:2], 2'b00}) begin
        errors++;
        $display("FAIL %s_wait got rmask=%b stall=%b addr=%h want 0000 1 %h",
                 name, dmem_rmask, mem_stall, dmem_addr, {a[31:2], 2'b00});
      end
      @(posedge clk);
    end
    @(negedge clk);
    dmem_resp = 1'b1;
    dmem_rdata = rdata;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_stall got %b want 0", name, mem_stall);
    end
    exp_q.push_back(exp_wb(e, 1'b1, exp_data));
    @(posedge clk);
    #1;
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if (mem_wb !== got_exp) begin
      errors++;
      $display("FAIL %s_mem_wb got rdata=%h rec=%h want rdata=%h rec=%h",
               name, mem_wb.mem_rdata, mem_wb, got_exp.mem_rdata, got_exp);
    end
    checks++;
    if (perf_stall_cnt !== cnt0 + 32'(waits + 1)) begin
      errors++;
      $display("FAIL %s_perf got %0d want %0d", name, perf_stall_cnt, cnt0 + 32'(waits + 1));
    end
  endtask

  task automatic test_store();
    ex_mem_stage_reg_t e;
    mem_wb_stage_reg_t got_exp;
    e = mk_op(op_store, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 1'b0);
    @(negedge clk);
    ex_mem = e;
    dmem_resp = 1'b0;
    #1;
    checks++;
    if (dmem_wmask !== 4'b1100 || dmem_rmask !== 4'b0 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL sh_request got wmask=%b rmask=%b stall=%b want 1100 0000 1",
               dmem_wmask, dmem_rmask, mem_stall);
    end
    checks++;
    if (dmem_wdata !== 32'hABCD_0000 || dmem_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL sh_data got wdata=%h addr=%h want abcd0000 00002000", dmem_wdata, dmem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || dmem_wmask !== 4'b0) begin
      errors++;
      $display("FAIL sh_resp got stall=%b wmask=%b want 0 0000", mem_stall, dmem_wmask);
    end
    exp_q.push_back(exp_wb(e, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if (mem_wb !== got_exp) begin
      errors++;
      $display("FAIL sh_mem_wb got %h want %h", mem_wb, got_exp);
    end
  endtask

  task automatic test_misalign();
    ex_mem_stage_reg_t e;
    mem_wb_stage_reg_t got_exp;
    mem_wb_stage_reg_t bubble;
    bubble = '0;
    e = mk_op(op_load, 3'b010, 32'h0000_2001, 32'h0, 1'b1);
    @(negedge clk);
    ex_mem = e;
    dmem_resp = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || dmem_rmask !== 4'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_issue got stall=%b rmask=%b err=%b want 0 0000 0",
               mem_stall, dmem_rmask, misalign_err);
    end
    exp_q.push_back(exp_wb(e, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if (mem_wb !== got_exp) begin
      errors++;
      $display("FAIL misalign_mem_wb got we=%b rec=%h want we=0 rec=%h",
               mem_wb.regf_we, mem_wb, got_exp);
    end
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse got %b want 1", misalign_err);
    end
    @(negedge clk);
    ex_mem.valid = 1'b0;
    exp_q.push_back(bubble);
    @(posedge clk);
    #1;
    got_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    checks++;
    if (mem_wb !== got_exp) begin
      errors++;
      $display("FAIL bubble_mem_wb got %h want %h", mem_wb, got_exp);
    end
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse_end got %b want 0", misalign_err);
    end
  endtask

  task automatic test_back_to_back();
    test_load("lhu_b2b", 3'b101, 32'h0000_3002, 32'hF00D_1234, 0, 4'b1100, 32'h0000_F00D);
    test_load("lh_b2b", 3'b001, 32'h0000_3000, 32'h5555_8001, 1, 4'b0011, 32'hFFFF_8001);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_mem = mk_op(op_load, 3'b010, 32'h0000_4000, 32'h0, 1'b1);
    dmem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ex_mem = '0;
    #1;
    checks++;
    if (mem_wb.valid !== 1'b0 || perf_stall_cnt !== 32'd0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state got valid=%b perf=%0d stall=%b want 0 0 0",
               mem_wb.valid, perf_stall_cnt, mem_stall);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || dmem_rmask !== 4'b0) begin
      errors++;
      $display("FAIL spurious_resp got stall=%b rmask=%b want 0 0000", mem_stall, dmem_rmask);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_wb.valid !== 1'b0 || mem_wb.mem_rdata !== 32'h0 || perf_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL spurious_capture got valid=%b rdata=%h perf=%0d want 0 0 0",
               mem_wb.valid, mem_wb.mem_rdata, perf_stall_cnt);
    end
    @(negedge clk);
    dmem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load("lw", 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 3, 4'b1111, 32'hDEAD_BEEF);
    test_load("lb", 3'b000, 32'h0000_1003, 32'h8012_3456, 1, 4'b1000, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h0000_1003, 32'h8012_3456, 1, 4'b1000, 32'h0000_0080);
    test_store();
    test_misalign();
    test_back_to_back();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage pipeline. Consumes the EX/MEM record produced by execute (`ex_mem_stage_reg_t`) and drives the data-memory request/response handshake.
- Aligns store data and extends load data.
- Owns the MEM/WB pipeline register (`mem_wb_stage_reg_t`).
- Raises `mem_stall` to freeze upstream stages while a data access is outstanding.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_mem  in  ex_mem_stage_reg_t  EX/MEM record; held stable by upstream while mem_stall=1
- mem_wb  out  mem_wb_stage_reg_t  registered MEM/WB record
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register
- dmem_addr  out  XLEN  word-aligned address ({alu_out[31:2],2'b00})
- dmem_rmask  out  4  byte read mask; nonzero only in the request cycle
- dmem_wmask  out  4  byte write mask; nonzero only in the request cycle
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_rdata  in  XLEN  read data, valid when dmem_resp=1
- dmem_resp  in  1  one-cycle completion pulse, earliest the cycle after the request
- misalign_err  out  1  registered one-cycle pulse on a misaligned access
- perf_stall_cnt  out  CNT_W  saturating count of cycles with mem_stall=1

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE
  - mem_wb all-zero (valid=0, regf_we=0)
  - misalign_err=0, perf_stall_cnt=0
  - dmem masks 0
- Reset mid-access abandons the request. A dmem_resp arriving afterwards in IDLE is ignored.
- mem_op = ex_mem.valid & (opcode==load | opcode==store). Address a = ex_mem.alu_out.
- Misaligned condition:
  - halfword with a[0]=1, or word with a[1:0]!=0
  - The access is not issued and mem_stall stays 0.
  - The instruction passes to mem_wb with regf_we forced 0; misalign_err pulses the next cycle.
- FSM: IDLE, WAIT.
  - IDLE with aligned mem_op:
    - drive dmem_addr and the masks for exactly this cycle; mem_stall=1; go to WAIT
    - loads: rmask = lb/lbu 0001<<a[1:0], lh/lhu 0011<<a[1:0], lw 1111
    - stores: wmask uses the same encoding by funct3; wdata = rs2_v << (8*a[1:0])
  - WAIT with dmem_resp=0: masks 0; mem_stall=1; dmem_addr held.
  - WAIT with dmem_resp=1: mem_stall=0; mem_wb captures the record with load data; go to IDLE. A back-to-back memory op is issued the following cycle from IDLE.
  - IDLE without mem_op: mem_stall=0; no request.
- Minimum memory-op latency is 2 cycles (request, response). Non-memory ops take 1 cycle.
- Load data path:
  - shifted = rdata >> (8*a[1:0])
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through
  - result goes to mem_wb.mem_rdata (load result field)
- mem_wb update: on every clock edge where mem_stall=0.
  - mem_wb copies pc, inst, rd_s, rs1_s/rs2_s, rs1_v/rs2_v, alu_out, br_en, u_imm, regfilemux_sel, regf_we and the physical-register fields (rs*_phys, dest_phys_new/old, dest_arch).
  - ex_mem.valid=0 produces a bubble: valid=0, regf_we=0.
- mem_stall is combinational from state, ex_mem and dmem_resp. It never depends on mem_wb.
- perf_stall_cnt increments each cycle mem_stall=1 and saturates at all-ones.
- A dmem_resp in IDLE (spurious) is ignored with no state change.

Decomposition:
- The rv32i_types package holds:
  - `mem_wb_stage_reg_t`, including a mem_rdata field and the physical-register fields
  - load_f3_t / store_f3_t enums (lb, lh, lw, lbu, lhu; sb, sh, sw)
  - mem_state_t {IDLE, WAIT}
- One combinational sub-module, mem_align: inputs funct3, opcode, addr[1:0], rs2_v, rdata; outputs rmask, wmask, wdata, load_data, misaligned. The FSM, registers and counter stay in mem_stage.

Test Plan:
- ADD with valid=1, alu_out=0x10 → no request, mem_stall=0, mem_wb.alu_out=0x10 and valid=1 next edge.
- LW a=0x1000, resp 3 cycles later with rdata=0xDEADBEEF:
  - request cycle: rmask=1111 for one cycle
  - mem_stall=1 for 4 cycles
  - mem_wb.mem_rdata=0xDEADBEEF after the resp edge
- LB a=0x1003, rdata=0x80xxxxxx → rmask=1000, mem_rdata=0xFFFFFF80; LBU same → 0x00000080.
- SH a=0x2002, rs2_v=0x1234ABCD → wmask=1100, wdata[31:16]=0xABCD, dmem_addr=0x2000.
- LW a=0x2001 → no request, mem_stall=0, mem_wb.regf_we=0, misalign_err=1 for exactly one cycle.
- rst_n low during WAIT, then dmem_resp pulses after release:
  - state IDLE, mem_wb.valid=0, no capture
  - perf_stall_cnt=0
